div_batch_requester: RTL
========================

Name: div_batch_requester

Overview:
- Initiator-side controller for the shared signed iterative divider used by the MHA datapath, for example in softmax normalisation: each exp value divided by the row sum.
- Accepts one batch configuration: a common divisor and an element count. It then takes numerators from an upstream stream and drives the divider's hold-until-valid start handshake one element at a time.
- Returns quotients on a downstream valid/ready stream. Divide-by-zero is resolved locally, and a watchdog guards against a hung divider.

Parameters:
- D_W, 16, operand and quotient width (signed two's complement).
- MAX_LEN, 64, maximum elements per batch.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- TIMEOUT, 64, maximum cycles O_DIV_START may stay high without I_OUT_VLD.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RST  in  1  synchronous reset, active-high.
- I_CFG_VLD  in  1  batch configuration strobe; sampled only in IDLE.
- I_CFG_DIVISOR  in  D_W  common signed divisor for the batch.
- I_CFG_LEN  in  LEN_W  number of elements; 0 is legal.
- O_BUSY  out  1  high in every state except IDLE.
- O_DONE  out  1  one-cycle pulse when the batch completes.
- O_ERR  out  1  sticky watchdog flag; cleared when the next configuration is accepted.
- I_NUM_VLD  in  1  upstream numerator valid.
- I_NUM  in  D_W  signed numerator.
- O_NUM_RDY  out  1  numerator ready.
- O_DIV_START  out  1  divider start; held high until I_OUT_VLD is seen.
- O_DIVIDEND  out  D_W  registered operand; stable while O_DIV_START is high.
- O_DIVISOR  out  D_W  registered operand; stable while O_DIV_START is high.
- I_QUOTIENT  in  D_W  divider result.
- I_OUT_VLD  in  1  divider result valid.
- O_Q_VLD  out  1  quotient valid.
- O_Q  out  D_W  signed quotient.
- O_Q_LAST  out  1  marks the final element of the batch.
- I_Q_RDY  in  1  downstream ready.

Behaviour:
- Reset: on any edge with I_RST=1, go to IDLE. All outputs go to 0, including O_ERR. Counters and operand registers clear. A reset mid-operation drops O_DIV_START at that same edge, with no wait for I_OUT_VLD. The divider is then expected to return to idle.
- All outputs are registered. Handshakes complete on any edge where valid and ready are both 1.
- FSM states: IDLE, FETCH, REQ, DROP, RESULT.
- IDLE, when I_CFG_VLD=1:
  - Latch divisor and length, set cnt=0, clear O_ERR.
  - If LEN=0: pulse O_DONE next cycle and stay in IDLE.
  - Otherwise: go to FETCH.
  - I_CFG_VLD is ignored while O_BUSY=1.
- FETCH:
  - O_NUM_RDY=1.
  - On I_NUM_VLD, latch I_NUM into O_DIVIDEND and the divisor into O_DIVISOR.
  - If divisor=0: the quotient is 0x7FFF (2^(D_W-1)-1) for numerator>=0, else 0x8000 (-2^(D_W-1)). Go straight to RESULT; O_DIV_START is never raised.
  - Otherwise: go to REQ.
- REQ:
  - O_DIV_START=1 from the first REQ cycle; the watchdog counter increments each cycle.
  - On I_OUT_VLD=1: capture I_QUOTIENT, deassert O_DIV_START at the next edge, go to DROP.
  - If the watchdog reaches TIMEOUT-1 with no I_OUT_VLD: quotient=0, set O_ERR, go to DROP.
- DROP:
  - O_DIV_START=0.
  - Remain until I_OUT_VLD=0, then go to RESULT.
  - No new start is issued while I_OUT_VLD is still high; this is the divider's required start-low/valid-low turnaround.
- RESULT:
  - O_Q_VLD=1; O_Q_LAST=1 when cnt=len-1.
  - On I_Q_RDY: cnt++.
  - If last: go to IDLE and pulse O_DONE on the following cycle. Otherwise go to FETCH.
  - O_Q and O_Q_LAST are stable while O_Q_VLD=1 and I_Q_RDY=0.
- Quotient semantics follow the divider: signed truncation toward zero. The local special case is only divisor=0. The requester passes -32768/-1 through unchanged from the divider.
- Throughput: at most one element in flight. Per element = 1 (FETCH) + divider latency + 1 (DROP, minimum) + 1 (RESULT, minimum) cycles.

Test Plan:
1. Reset held 3 cycles mid-REQ with O_DIV_START=1 -> all outputs 0 on the next edge; after release, state is IDLE and O_BUSY=0.
2. CFG divisor=7, LEN=3; numerators 100, -100, 6; I_Q_RDY=1; divider model obeys the hold-until-valid protocol -> O_Q=14, -14, 0, O_Q_LAST on the third only, O_DONE one pulse, O_DIV_START never rises while I_OUT_VLD=1.
3. CFG divisor=0, LEN=2, numerators 5 and -5 -> O_Q=0x7FFF then 0x8000, O_DIV_START stays 0 throughout.
4. Backpressure: I_Q_RDY low for 10 cycles in RESULT -> O_Q, O_Q_LAST stable and O_NUM_RDY=0 until accepted. I_CFG_VLD pulsed while busy -> ignored.
5. Divider model never asserts I_OUT_VLD, TIMEOUT=64 -> O_DIV_START drops after 64 high cycles, O_Q=0, O_ERR=1 and stays high until the next configuration is accepted.
6. CFG LEN=0 -> O_DONE pulse the next cycle, no O_NUM_RDY, no O_Q_VLD. Random regression of 1000 elements against a $signed division reference model -> zero mismatches.

Source files
------------

// File: rtl/div_batch_requester.sv
// Batch requester for the shared signed iterative divider: one divisor, LEN numerators in, LEN quotients out.
// Latency per element: 1 FETCH + divider latency + >=1 DROP + >=1 RESULT cycles; one element in flight.
// Backpressure: O_NUM_RDY only in FETCH; a stalled quotient (I_Q_RDY=0) holds O_Q/O_Q_LAST and blocks fetching.
module div_batch_requester #(
  parameter int D_W     = 16,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT = 64
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  // batch configuration
  input  logic             I_CFG_VLD,
  input  logic [D_W-1:0]   I_CFG_DIVISOR,
  input  logic [LEN_W-1:0] I_CFG_LEN,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic             O_ERR,
  // numerator stream
  input  logic             I_NUM_VLD,
  input  logic [D_W-1:0]   I_NUM,
  output logic             O_NUM_RDY,
  // divider start/result handshake
  output logic             O_DIV_START,
  output logic [D_W-1:0]   O_DIVIDEND,
  output logic [D_W-1:0]   O_DIVISOR,
  input  logic [D_W-1:0]   I_QUOTIENT,
  input  logic             I_OUT_VLD,
  // quotient stream
  output logic             O_Q_VLD,
  output logic [D_W-1:0]   O_Q,
  output logic             O_Q_LAST,
  input  logic             I_Q_RDY
);

  // Watchdog wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  // Divide-by-zero saturation values, chosen by numerator sign.
  localparam logic [D_W-1:0] Q_POS_SAT = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0] Q_NEG_SAT = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_DROP,
    S_RESULT
  } state_t;

  state_t           state;
  logic [D_W-1:0]   divisor_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [WD_W-1:0]  wdog;
  logic             is_last;
  logic             num_fire;
  logic             q_fire;

  // Element index compare and handshake strobes.
  always_comb begin
    is_last  = (cnt == (len_r - LEN_W'(1)));
    num_fire = O_NUM_RDY & I_NUM_VLD;
    q_fire   = O_Q_VLD & I_Q_RDY;
  end

  // Batch FSM; every output is a register updated here.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state       <= S_IDLE;
      divisor_r   <= '0;
      len_r       <= '0;
      cnt         <= '0;
      wdog        <= '0;
      O_BUSY      <= 1'b0;
      O_DONE      <= 1'b0;
      O_ERR       <= 1'b0;
      O_NUM_RDY   <= 1'b0;
      O_DIV_START <= 1'b0;
      O_DIVIDEND  <= '0;
      O_DIVISOR   <= '0;
      O_Q_VLD     <= 1'b0;
      O_Q         <= '0;
      O_Q_LAST    <= 1'b0;
    end else begin
      O_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_CFG_VLD) begin
            divisor_r <= I_CFG_DIVISOR;
            len_r     <= I_CFG_LEN;
            cnt       <= '0;
            O_ERR     <= 1'b0;
            if (I_CFG_LEN == '0) begin
              // Empty batch completes immediately without leaving IDLE.
              O_DONE <= 1'b1;
            end else begin
              state     <= S_FETCH;
              O_BUSY    <= 1'b1;
              O_NUM_RDY <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (num_fire) begin
            O_NUM_RDY  <= 1'b0;
            O_DIVIDEND <= I_NUM;
            O_DIVISOR  <= divisor_r;
            if (divisor_r == '0) begin
              // Resolve divide-by-zero locally; the divider is never started.
              O_Q      <= I_NUM[D_W-1] ? Q_NEG_SAT : Q_POS_SAT;
              O_Q_VLD  <= 1'b1;
              O_Q_LAST <= is_last;
              state    <= S_RESULT;
            end else begin
              O_DIV_START <= 1'b1;
              wdog        <= '0;
              state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (I_OUT_VLD) begin
            O_Q         <= I_QUOTIENT;
            O_DIV_START <= 1'b0;
            state       <= S_DROP;
          end else if (wdog == WD_LAST) begin
            // Divider hung: abandon the element with a zero quotient.
            O_Q         <= '0;
            O_ERR       <= 1'b1;
            O_DIV_START <= 1'b0;
            state       <= S_DROP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        S_DROP: begin
          // Wait for the divider's valid to fall before anything else can start.
          if (!I_OUT_VLD) begin
            O_Q_VLD  <= 1'b1;
            O_Q_LAST <= is_last;
            state    <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (q_fire) begin
            O_Q_VLD  <= 1'b0;
            O_Q_LAST <= 1'b0;
            cnt      <= cnt + LEN_W'(1);
            if (O_Q_LAST) begin
              state  <= S_IDLE;
              O_BUSY <= 1'b0;
              O_DONE <= 1'b1;
            end else begin
              state     <= S_FETCH;
              O_NUM_RDY <= 1'b1;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          O_BUSY      <= 1'b0;
          O_NUM_RDY   <= 1'b0;
          O_DIV_START <= 1'b0;
          O_Q_VLD     <= 1'b0;
          O_Q_LAST    <= 1'b0;
        end
      endcase
    end
  end

endmodule
